// File: rtl/regfile_writeback_pkg.sv
// Shared writeback types: register-file geometry and the {dst, data} request
// carried by the execute, memory and writeback stages.
package regfile_writeback_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] dst;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  function automatic logic [NUM_REGS-1:0] dstOnehot(input logic [ADDR_W-1:0] dst);
    logic [NUM_REGS-1:0] mask;
    mask      = {NUM_REGS{1'b0}};
    mask[dst] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/regfile_writeback_fifo.sv
// Synchronous FIFO of writeback requests. The count is kept separately from
// the pointers, so full and empty stay distinct at DEPTH.
module wb_fifo
  import regfile_writeback_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  wb_req_t               pushReq,
  input  logic                  pop,
  output wb_req_t               head,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty,
  output wb_req_t [DEPTH-1:0]   slots,
  output logic [DEPTH-1:0]      slotValid,
  output logic [PTR_W-1:0]      rdPtr
);

  logic [PTR_W-1:0]              wrPtr;
  wb_req_t [DEPTH-1:0]           store;
  logic [DEPTH-1:0][PTR_W-1:0]   slotOff;
  logic                          doPush;
  logic                          doPop;

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == CNT_W'(0));
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign head   = store[rdPtr];
  assign slots  = store;

  // Pointer and occupancy state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= PTR_W'(0);
      rdPtr <= PTR_W'(0);
      count <= CNT_W'(0);
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage; contents are dropped on reset simply by clearing the count.
  always_ff @(posedge clk) begin
    if (doPush) store[wrPtr] <= pushReq;
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slotOff[i]   = PTR_W'(i) - rdPtr;
      slotValid[i] = (CNT_W'(slotOff[i]) < count);
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback arbiter: merges the ALU stream and buffered memory returns onto the
// register file's single write port and tracks registers with writes in flight.
module regfile_writeback #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_W-1:0]     alu_dst,
  input  logic [DATA_W-1:0]     alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [ADDR_W-1:0]     mem_dst,
  input  logic [DATA_W-1:0]     mem_data,
  output logic [ADDR_W-1:0]     DstReg,
  output logic [DATA_W-1:0]     DstData,
  output logic                  WriteReg,
  output logic [2**ADDR_W-1:0]  pend_mask,
  output logic [CNT_W-1:0]      fifo_count
);

  import regfile_writeback_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int NREGS = 2 ** ADDR_W;

  wb_req_t               aluReq;
  wb_req_t               memReq;
  wb_req_t               fifoHead;
  wb_req_t               grantReq;
  wb_req_t [DEPTH-1:0]   fifoSlots;
  logic [DEPTH-1:0]      fifoSlotValid;
  logic [PTR_W-1:0]      fifoRdPtr;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic                  memPush;
  logic                  popGrant;
  logic                  aluGrant;
  logic [NREGS-1:0]      pendNext;

  assign aluReq    = '{dst: alu_dst, data: alu_data};
  assign memReq    = '{dst: mem_dst, data: mem_data};
  assign alu_ready = (fifo_count != CNT_W'(DEPTH));
  assign mem_ready = (fifo_count < CNT_W'(DEPTH));
  // Loads to r0 are acknowledged but never occupy a slot.
  assign memPush   = mem_valid && mem_ready && (mem_dst != ADDR_W'(0));

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (memPush),
    .pushReq   (memReq),
    .pop       (popGrant),
    .head      (fifoHead),
    .count     (fifo_count),
    .full      (fifoFull),
    .empty     (fifoEmpty),
    .slots     (fifoSlots),
    .slotValid (fifoSlotValid),
    .rdPtr     (fifoRdPtr)
  );

  // Port grant: memory drains when full or when the ALU is idle, else the ALU goes.
  always_comb begin
    popGrant = 1'b0;
    aluGrant = 1'b0;
    grantReq = aluReq;
    if (!fifoEmpty && (fifoFull || !alu_valid)) begin
      popGrant = 1'b1;
      grantReq = fifoHead;
    end else if (alu_valid && alu_ready) begin
      aluGrant = 1'b1;
    end else begin
      popGrant = 1'b0;
      aluGrant = 1'b0;
    end
  end

  // Pending mask as it will stand after this edge: surviving slots, the new push, the new write.
  always_comb begin
    pendNext = {NREGS{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      pendNext = pendNext |
                 ((fifoSlotValid[i] && !(popGrant && (fifoRdPtr == PTR_W'(i))))
                  ? dstOnehot(fifoSlots[i].dst) : {NREGS{1'b0}});
    end
    pendNext    = pendNext | (memPush ? dstOnehot(mem_dst) : {NREGS{1'b0}});
    pendNext    = pendNext | ((popGrant || aluGrant) ? dstOnehot(grantReq.dst) : {NREGS{1'b0}});
    pendNext[0] = 1'b0;
  end

  // Registered write port and pending mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WriteReg  <= 1'b0;
      DstReg    <= ADDR_W'(0);
      DstData   <= DATA_W'(0);
      pend_mask <= {NREGS{1'b0}};
    end else begin
      pend_mask <= pendNext;
      if (popGrant || aluGrant) begin
        DstReg   <= grantReq.dst;
        DstData  <= grantReq.data;
        WriteReg <= (grantReq.dst != ADDR_W'(0));
      end else begin
        WriteReg <= 1'b0;
      end
    end
  end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Writeback arbiter and port driver for the 16-entry, 16-bit register file. Merges two producers, a single-cycle ALU result stream and a variable-latency memory/load return stream, onto the register file's single write port (DstReg/DstData/WriteReg). Memory returns are buffered in a small FIFO. A per-register pending mask is exported so hazard logic can stall reads of registers with writes still in flight. Sits between the execute/memory stages and the register file.

## Interface
Parameters:
- DATA_W, 16, register data width
- ADDR_W, 4, register index width (2**ADDR_W registers)
- DEPTH, 4, memory-return FIFO depth; power of two, at least 2

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request accepted this cycle when high with alu_valid
- alu_dst  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  memory writeback request
- mem_ready  out  1  memory request accepted when high with mem_valid
- mem_dst  in  ADDR_W  memory destination register
- mem_data  in  DATA_W  load data
- DstReg  out  ADDR_W  register file write index (registered)
- DstData  out  DATA_W  register file write data (registered)
- WriteReg  out  1  register file write enable (registered)
- pend_mask  out  2**ADDR_W  bit r high means a write to register r is buffered or on the port
- fifo_count  out  $clog2(DEPTH+1)  current memory FIFO occupancy

## Operation
- Handshakes are valid/ready. A transfer occurs when both are high at a rising edge. Producers hold dst and data stable while valid is high and ready is low.
- mem_ready = (fifo_count < DEPTH). An accepted memory request is pushed into the FIFO. Push and pop in the same cycle are allowed when not full.
- alu_ready = (fifo_count != DEPTH). ALU is stalled only when the FIFO is full.
- Grant, each cycle, in priority order:
  - FIFO non-empty and (FIFO full or !alu_valid): pop the FIFO head.
  - Otherwise, alu_valid and alu_ready: take the ALU request.
  - Otherwise: no grant.
- Output stage registers the granted request.
  - WriteReg = 1 only if dst != 0.
  - DstReg and DstData take the granted values.
  - With no grant, WriteReg = 0 and DstReg/DstData hold their previous values.
- Register 0 is hardwired zero:
  - An ALU request with dst 0 is accepted and produces no write.
  - A memory request with dst 0 is accepted and not pushed; fifo_count is unchanged.
- Ordering:
  - Memory returns are written in acceptance order.
  - ALU and memory writes to the same register are written in grant order. The producer side guarantees it never has both outstanding to the same register.
- pend_mask = OR over valid FIFO entries of onehot(dst), OR onehot(DstReg) when WriteReg. Bit 0 is always 0.

## Timing
- Reset (asynchronous, any cycle, including mid-drain):
  - FIFO pointers and count cleared, FIFO contents discarded.
  - WriteReg=0, DstReg=0, DstData=0, pend_mask=0, fifo_count=0.
  - alu_ready=1, mem_ready=1 while rst is low after release.
- ALU latency: accept at edge N, so WriteReg/DstReg/DstData are valid in cycle N+1 and the register file write commits at edge N+1.
- Memory latency: at least 2 cycles. Push at edge N, pop no earlier than edge N+1, WriteReg high in cycle N+2.
- Full boundary:
  - fifo_count==DEPTH forces mem_ready=0 and alu_ready=0, and the head pops that cycle.
  - fifo_count returns to DEPTH-1 next cycle, so ALU is stalled at most 1 cycle per full event.
- Empty boundary: pop is never granted when fifo_count==0. ALU then has the port every cycle.
- Pointers wrap modulo DEPTH. fifo_count is exact at DEPTH (no full/empty aliasing).
- pend_mask is registered state: it updates at the same edge as the push or grant that changes it.

## Structure
- Shared package: DATA_W, ADDR_W constants, and typedef wb_req_t {dst, data}, also used by the execute and memory stages.
- One sub-module, wb_fifo: a parameterised synchronous FIFO of wb_req_t with push, pop, head, count, full, and empty.
- Grant logic, output register, and pend_mask stay in regfile_writeback.

## Test plan
- Reset, then an ALU stream to r2=ABCD, r5=1234, with mem idle.
  - WriteReg pulses one cycle after each acceptance with matching DstReg/DstData.
  - pend_mask shows bit 2, then bit 5.
- Memory request r7=5555 with ALU idle.
  - fifo_count=1 the next cycle.
  - WriteReg with DstReg=7 and DstData=5555 two cycles after acceptance.
  - pend_mask bit 7 is set from the push until the write cycle ends.
- Hold alu_valid continuously (r3, data 0x3000+i) and push 5 memory returns (r8..r12).
  - FIFO reaches 4 and mem_ready=0.
  - The head pops with alu_ready=0 for exactly 1 cycle.
  - All 5 loads are written in order, and no ALU write is lost.
- alu_dst=0 with data FFFF, and mem_dst=0 with data 1000.
  - Both are accepted.
  - WriteReg never rises, fifo_count stays 0, and pend_mask bit 0 stays 0.
- FIFO holding 3 entries, then rst asserted mid-cycle, asynchronously.
  - All outputs are zero immediately.
  - After release, no stale write appears.
- Sequential sweep: registers 1..15 written with 0x1000+i, alternating ALU and memory.
  - Each index appears exactly once on DstReg with the correct data.
